// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - sync checker for an 8-bit XNOR LFSR stream (taps 7,3)
// Hunts for 8 bits, verifies LOCK_CNT predictions, then tracks errors while locked.
module lfsr_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_ERRS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clear_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic        sync_loss,
  output logic [15:0] err_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_V = LOCK_CNT[7:0];
  localparam logic [3:0] LOSS_V = LOSS_ERRS[3:0];

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_hist;
  logic [3:0]  r_fill_cnt;
  logic [3:0]  w_fill_nxt;
  logic [7:0]  r_good_cnt;
  logic [7:0]  w_good_nxt;
  logic [3:0]  r_miss_cnt;
  logic [3:0]  w_miss_nxt;
  logic [15:0] r_err_count;
  logic        r_locked;
  logic        r_err_pulse;
  logic        r_sync_loss;
  logic        w_expected;
  logic        w_mismatch;
  logic        w_err;
  logic        w_loss;

  // All-ones history is the XNOR lock-up state, so it never counts as a match.
  assign w_expected = ~(r_hist[7] ^ r_hist[3]);
  assign w_mismatch = (bit_in != w_expected) || (r_hist == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt;
    w_good_nxt  = r_good_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err       = 1'b0;
    w_loss      = 1'b0;
    if (bit_valid) begin
      case (r_state)
        HUNT: begin
          if (r_fill_cnt == 4'd7) begin
            w_state_nxt = VERIFY;
            w_fill_nxt  = 4'd0;
            w_good_nxt  = 8'd0;
          end else begin
            w_fill_nxt = r_fill_cnt + 4'd1;
          end
        end
        VERIFY: begin
          if (w_mismatch) begin
            w_good_nxt = 8'd0;
          end else if (r_good_cnt + 8'd1 == LOCK_V) begin
            w_state_nxt = LOCKED;
            w_good_nxt  = 8'd0;
            w_miss_nxt  = 4'd0;
          end else begin
            w_good_nxt = r_good_cnt + 8'd1;
          end
        end
        LOCKED: begin
          if (w_mismatch) begin
            w_err = 1'b1;
            if (r_miss_cnt + 4'd1 == LOSS_V) begin
              w_state_nxt = HUNT;
              w_fill_nxt  = 4'd0;
              w_miss_nxt  = 4'd0;
              w_loss      = 1'b1;
            end else begin
              w_miss_nxt = r_miss_cnt + 4'd1;
            end
          end else begin
            w_miss_nxt = 4'd0;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist      <= 8'd0;
      r_fill_cnt  <= 4'd0;
      r_good_cnt  <= 8'd0;
      r_miss_cnt  <= 4'd0;
      r_err_count <= 16'd0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_sync_loss <= 1'b0;
    end else begin
      if (bit_valid) begin
        r_hist <= {r_hist[6:0], bit_in};
      end
      r_fill_cnt  <= w_fill_nxt;
      r_good_cnt  <= w_good_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_err_pulse <= w_err;
      r_sync_loss <= w_loss;
      if (clear_cnt) begin
        r_err_count <= 16'd0;
      end else if (w_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign sync_loss = r_sync_loss;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed bench for lfsr_checker
// Segment table over a reference stream, plus gap/clear/reset/stuck-line sequences.
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic        sync_loss;
  logic [15:0] err_count;
  logic [1:0]  state;

  lfsr_checker #(.LOCK_CNT(16), .LOSS_ERRS(4)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .sync_loss (sync_loss),
    .err_count (err_count),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        flip;
    logic [1:0]  st;
    logic        lk;
    logic [15:0] ec;
    int          np;
    int          nl;
  } seg_t;

  seg_t       segs[15];
  logic [7:0] g;
  int         n_cmp;
  int         n_bad;
  int         pulse_acc;
  int         loss_acc;
  logic       ever_locked;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic gen_next(output logic b);
    b = ~(g[7] ^ g[3]);
    g = {g[6:0], b};
  endtask

  task automatic send_bit(input logic b, input logic v, input logic clr);
    @(negedge clk);
    bit_in    = b;
    bit_valid = v;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    if (err_pulse) pulse_acc++;
    if (sync_loss) loss_acc++;
    if (locked) ever_locked = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    clear_cnt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g = 8'd0;
    pulse_acc = 0;
    loss_acc = 0;
    ever_locked = 1'b0;
  endtask

  initial begin
    logic nb;
    int   vcnt;
    int   cyc;
    int   gap_bad;
    logic [1:0] prev_st;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    g = 8'd0;

    // n, flip, state, locked, err_count, pulses, sync_losses (cumulative err_count)
    segs[0]  = '{7,   1'b0, 2'd0, 1'b0, 16'd0, 0, 0};
    segs[1]  = '{1,   1'b0, 2'd1, 1'b0, 16'd0, 0, 0};
    segs[2]  = '{15,  1'b0, 2'd1, 1'b0, 16'd0, 0, 0};
    segs[3]  = '{1,   1'b0, 2'd2, 1'b1, 16'd0, 0, 0};
    segs[4]  = '{276, 1'b0, 2'd2, 1'b1, 16'd0, 0, 0};
    segs[5]  = '{1,   1'b1, 2'd2, 1'b1, 16'd1, 1, 0};
    segs[6]  = '{3,   1'b0, 2'd2, 1'b1, 16'd1, 0, 0};
    segs[7]  = '{1,   1'b0, 2'd2, 1'b1, 16'd2, 1, 0};
    segs[8]  = '{3,   1'b0, 2'd2, 1'b1, 16'd2, 0, 0};
    segs[9]  = '{1,   1'b0, 2'd2, 1'b1, 16'd3, 1, 0};
    segs[10] = '{8,   1'b0, 2'd2, 1'b1, 16'd3, 0, 0};
    segs[11] = '{3,   1'b1, 2'd2, 1'b1, 16'd6, 3, 0};
    segs[12] = '{1,   1'b1, 2'd0, 1'b0, 16'd7, 1, 1};
    segs[13] = '{8,   1'b0, 2'd1, 1'b0, 16'd7, 0, 0};
    segs[14] = '{16,  1'b0, 2'd2, 1'b1, 16'd7, 0, 0};

    #23;
    chk("reset_state", {30'd0, state}, 0);
    chk("reset_locked", {31'd0, locked}, 0);
    chk("reset_err_count", {16'd0, err_count}, 0);
    chk("reset_err_pulse", {31'd0, err_pulse}, 0);
    chk("reset_sync_loss", {31'd0, sync_loss}, 0);

    do_reset();
    for (int s = 0; s < 15; s++) begin
      pulse_acc = 0;
      loss_acc = 0;
      for (int i = 0; i < segs[s].n; i++) begin
        gen_next(nb);
        send_bit(segs[s].flip ? ~nb : nb, 1'b1, 1'b0);
      end
      chk($sformatf("seg%0d_state", s), {30'd0, state}, {30'd0, segs[s].st});
      chk($sformatf("seg%0d_locked", s), {31'd0, locked}, {31'd0, segs[s].lk});
      chk($sformatf("seg%0d_err_count", s), {16'd0, err_count}, {16'd0, segs[s].ec});
      chk($sformatf("seg%0d_pulses", s), pulse_acc, segs[s].np);
      chk($sformatf("seg%0d_sync_loss", s), loss_acc, segs[s].nl);
    end

    // Gapped stream: lock point measured in valid bits only.
    do_reset();
    vcnt = 0;
    cyc = 0;
    gap_bad = 0;
    prev_st = state;
    while (vcnt < 24 && cyc < 400) begin
      cyc++;
      if ($urandom_range(1) == 0) begin
        send_bit(1'($urandom_range(1)), 1'b0, 1'b0);
        if (err_pulse || sync_loss || state != prev_st) gap_bad++;
      end else begin
        gen_next(nb);
        send_bit(nb, 1'b1, 1'b0);
        vcnt++;
        if (vcnt == 8)  chk("gap_verify_at_8", {30'd0, state}, 1);
        if (vcnt == 23) chk("gap_unlocked_at_23", {31'd0, locked}, 0);
        if (vcnt == 24) chk("gap_locked_at_24", {31'd0, locked}, 1);
      end
      prev_st = state;
    end
    chk("gap_budget", vcnt, 24);
    chk("gap_idle_clean", gap_bad, 0);

    // clear_cnt coinciding with an error wins over the increment.
    gen_next(nb);
    send_bit(~nb, 1'b1, 1'b1);
    chk("clr_err_pulse", {31'd0, err_pulse}, 1);
    chk("clr_priority", {16'd0, err_count}, 0);
    for (int i = 0; i < 4; i++) begin
      gen_next(nb);
      send_bit(nb, 1'b1, 1'b0);
    end
    chk("clr_then_count", {16'd0, err_count}, 1);
    gen_next(nb);
    send_bit(nb, 1'b1, 1'b1);
    chk("clr_alone", {16'd0, err_count}, 0);
    chk("clr_keeps_lock", {31'd0, locked}, 1);
    for (int i = 0; i < 3; i++) begin
      gen_next(nb);
      send_bit(nb, 1'b1, 1'b0);
    end
    chk("clr_third_error", {16'd0, err_count}, 1);

    // Asynchronous reset between edges while locked.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_locked", {31'd0, locked}, 0);
    chk("areset_err_count", {16'd0, err_count}, 0);
    chk("areset_state", {30'd0, state}, 0);
    chk("areset_sync_loss", {31'd0, sync_loss}, 0);
    @(posedge clk);
    #1;
    chk("areset_no_loss_pulse", {31'd0, sync_loss}, 0);

    // Stuck-at-1 and stuck-at-0 lines never lock.
    do_reset();
    for (int i = 0; i < 300; i++) send_bit(1'b1, 1'b1, 1'b0);
    chk("stuck1_never_locked", {31'd0, ever_locked}, 0);
    chk("stuck1_state", {30'd0, state}, 1);
    do_reset();
    for (int i = 0; i < 300; i++) send_bit(1'b0, 1'b1, 1'b0);
    chk("stuck0_never_locked", {31'd0, ever_locked}, 0);
    chk("stuck0_state", {30'd0, state}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
